// File: rtl/ctrl_pkg.sv
// Shared definitions for the pipelined main control: opcodes, ALUOp codes,
// the per-instruction control bundle and the stall FSM encoding.
package ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_RFN = 2'b10;
  localparam logic [1:0] ALU_IFN = 2'b11;

  typedef struct packed {
    logic       alusrc;
    logic [1:0] aluop;
    logic       mread;
    logic       mwrite;
    logic       branch;
    logic       regwr;
    logic       memtoreg;
  } ctrl_bundle_t;

  localparam int CTRL_W = $bits(ctrl_bundle_t);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } ctrl_state_t;

endpackage

// File: rtl/ctrl_pipe_unit_if.sv
// ID-stage inputs and per-stage control outputs of the pipelined control unit.
interface ctrl_pipe_unit_if #(
  parameter int REG_AW  = 5,
  parameter int ALUOP_W = 2
);
  logic [6:0]         opcode_i;
  logic               id_valid_i;
  logic [REG_AW-1:0]  rs1_i;
  logic [REG_AW-1:0]  rs2_i;
  logic [REG_AW-1:0]  rd_i;
  logic               flush_i;
  logic               stall_o;
  logic               ex_alusrc_o;
  logic [ALUOP_W-1:0] ex_aluop_o;
  logic [REG_AW-1:0]  ex_rd_o;
  logic               mem_read_o;
  logic               mem_write_o;
  logic               mem_branch_o;
  logic               wb_regwr_o;
  logic               wb_memtoreg_o;
  logic               illegal_o;

  modport master (
    output opcode_i, id_valid_i, rs1_i, rs2_i, rd_i, flush_i,
    input  stall_o, ex_alusrc_o, ex_aluop_o, ex_rd_o, mem_read_o, mem_write_o,
           mem_branch_o, wb_regwr_o, wb_memtoreg_o, illegal_o
  );

  modport slave (
    input  opcode_i, id_valid_i, rs1_i, rs2_i, rd_i, flush_i,
    output stall_o, ex_alusrc_o, ex_aluop_o, ex_rd_o, mem_read_o, mem_write_o,
           mem_branch_o, wb_regwr_o, wb_memtoreg_o, illegal_o
  );
endinterface

// File: rtl/ctrl_decode.sv
// Pure combinational opcode-to-control-bundle decoder for the ID stage.
import ctrl_pkg::*;

module ctrl_decode (
  input  logic [6:0]   i_opcode,
  input  logic         i_valid,
  input  logic         i_rd_zero,
  output ctrl_bundle_t o_bundle,
  output logic         o_legal
);

  always_comb begin
    o_bundle = ctrl_bundle_t'({CTRL_W{1'b0}});
    o_legal  = 1'b1;
    case (i_opcode)
      OP_R: begin
        o_bundle.aluop = ALU_RFN;
        o_bundle.regwr = 1'b1;
      end
      OP_I: begin
        o_bundle.aluop  = ALU_IFN;
        o_bundle.alusrc = 1'b1;
        o_bundle.regwr  = 1'b1;
      end
      OP_LOAD: begin
        o_bundle.aluop    = ALU_ADD;
        o_bundle.alusrc   = 1'b1;
        o_bundle.mread    = 1'b1;
        o_bundle.regwr    = 1'b1;
        o_bundle.memtoreg = 1'b1;
      end
      OP_STORE: begin
        o_bundle.aluop  = ALU_ADD;
        o_bundle.alusrc = 1'b1;
        o_bundle.mwrite = 1'b1;
      end
      OP_BRANCH: begin
        o_bundle.aluop  = ALU_SUB;
        o_bundle.branch = 1'b1;
      end
      default: o_legal = 1'b0;
    endcase
    // x0 is hardwired, so a write to it is dropped here rather than in WB
    if (!i_valid) o_bundle = ctrl_bundle_t'({CTRL_W{1'b0}});
    if (i_rd_zero) o_bundle.regwr = 1'b0;
  end

endmodule

// File: rtl/ctrl_pipe_unit.sv
// Pipelined main control: ID decode, ID/EX, EX/MEM, MEM/WB control registers and load-use stall FSM.
// Optional sticky illegal-opcode flag enabled by defining CTRL_ILLEGAL_EN.
import ctrl_pkg::*;

module ctrl_pipe_unit #(
  parameter int REG_AW    = 5,
  parameter int ALUOP_W   = 2,
  parameter int STALL_CYC = 1
) (
  input logic             clk_i,
  input logic             rst_i,
  ctrl_pipe_unit_if.slave bus
);

  ctrl_bundle_t      w_dec;
  logic              w_legal;
  logic              w_rd_zero;
  logic [REG_AW-1:0] w_dec_rd;
  logic              w_loaduse;
  logic              w_stall;
  logic              w_bubble;

  ctrl_bundle_t      r_idex;
  logic [REG_AW-1:0] r_idex_rd;
  logic              r_mem_read, r_mem_write, r_mem_branch, r_mem_regwr, r_mem_m2r;
  logic              r_wb_regwr, r_wb_m2r;
  ctrl_state_t       r_state;
  logic [2:0]        r_cnt;

  assign w_rd_zero = (bus.rd_i == '0);

  ctrl_decode u_decode (
    .i_opcode  (bus.opcode_i),
    .i_valid   (bus.id_valid_i),
    .i_rd_zero (w_rd_zero),
    .o_bundle  (w_dec),
    .o_legal   (w_legal)
  );

  assign w_dec_rd  = (bus.id_valid_i && w_legal) ? bus.rd_i : '0;
  assign w_loaduse = (r_state == ST_RUN) && r_idex.mread && (r_idex_rd != '0) &&
                     bus.id_valid_i && ((r_idex_rd == bus.rs1_i) || (r_idex_rd == bus.rs2_i));
  assign w_stall   = (r_state == ST_STALL) || (w_loaduse && !bus.flush_i);
  assign w_bubble  = w_stall || bus.flush_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_idex       <= '0;
      r_idex_rd    <= '0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_branch <= 1'b0;
      r_mem_regwr  <= 1'b0;
      r_mem_m2r    <= 1'b0;
      r_wb_regwr   <= 1'b0;
      r_wb_m2r     <= 1'b0;
    end else begin
      r_idex       <= w_bubble ? '0 : w_dec;
      r_idex_rd    <= w_bubble ? '0 : w_dec_rd;
      r_mem_read   <= r_idex.mread;
      r_mem_write  <= r_idex.mwrite;
      r_mem_branch <= r_idex.branch;
      r_mem_regwr  <= r_idex.regwr;
      r_mem_m2r    <= r_idex.memtoreg;
      r_wb_regwr   <= r_mem_regwr;
      r_wb_m2r     <= r_mem_m2r;
    end
  end

  // The detection cycle in RUN already counts as the first stall cycle,
  // so STALL only covers the remaining STALL_CYC-1 cycles.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= ST_RUN;
      r_cnt   <= '0;
    end else if (bus.flush_i) begin
      r_state <= ST_RUN;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_loaduse) begin
            r_cnt   <= 3'(STALL_CYC - 1);
            r_state <= (STALL_CYC > 1) ? ST_STALL : ST_RUN;
          end
        end
        ST_STALL: begin
          if (r_cnt <= 3'd1) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
      endcase
    end
  end

  assign bus.stall_o       = w_stall;
  assign bus.ex_alusrc_o   = r_idex.alusrc;
  assign bus.ex_aluop_o    = ALUOP_W'(r_idex.aluop);
  assign bus.ex_rd_o       = r_idex_rd;
  assign bus.mem_read_o    = r_mem_read;
  assign bus.mem_write_o   = r_mem_write;
  assign bus.mem_branch_o  = r_mem_branch;
  assign bus.wb_regwr_o    = r_wb_regwr;
  assign bus.wb_memtoreg_o = r_wb_m2r;

`ifdef CTRL_ILLEGAL_EN
  logic r_illegal;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_illegal <= 1'b0;
    else if (bus.id_valid_i && !w_legal) r_illegal <= 1'b1;
  end

  assign bus.illegal_o = r_illegal;
`else
  assign bus.illegal_o = 1'b0;
`endif

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// Bench for ctrl_pipe_unit: two instances (STALL_CYC 1 and 3) driven with identical
// stimulus and compared every cycle against a stage-queue reference model.
module tb_ctrl_pipe_unit;

  typedef struct packed {
    logic       alusrc;
    logic [1:0] aluop;
    logic       mread;
    logic       mwrite;
    logic       branch;
    logic       regwr;
    logic       m2r;
    logic [4:0] rd;
  } stage_t;

  typedef struct packed {
    logic       stall;
    logic       alusrc;
    logic [1:0] aluop;
    logic [4:0] rd;
    logic       mread;
    logic       mwrite;
    logic       branch;
    logic       regwr;
    logic       m2r;
    logic       illegal;
  } obs_t;

  localparam logic [6:0] OPC_R = 7'b0110011, OPC_I = 7'b0010011, OPC_LD = 7'b0000011;
  localparam logic [6:0] OPC_ST = 7'b0100011, OPC_BR = 7'b1100011, OPC_BAD = 7'b1111111;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  logic [6:0] opc;
  logic vld, flush;
  logic [4:0] rs1, rs2, rd;
  int checks, errors;

  ctrl_pipe_unit_if #(.REG_AW(5), .ALUOP_W(2)) bus1 ();
  ctrl_pipe_unit_if #(.REG_AW(5), .ALUOP_W(2)) bus3 ();

  ctrl_pipe_unit #(.REG_AW(5), .ALUOP_W(2), .STALL_CYC(1)) dut1 (.clk_i(clk), .rst_i(rstN), .bus(bus1));
  ctrl_pipe_unit #(.REG_AW(5), .ALUOP_W(2), .STALL_CYC(3)) dut3 (.clk_i(clk), .rst_i(rstN), .bus(bus3));

  assign bus1.opcode_i = opc;   assign bus3.opcode_i = opc;
  assign bus1.id_valid_i = vld; assign bus3.id_valid_i = vld;
  assign bus1.rs1_i = rs1;      assign bus3.rs1_i = rs1;
  assign bus1.rs2_i = rs2;      assign bus3.rs2_i = rs2;
  assign bus1.rd_i = rd;        assign bus3.rd_i = rd;
  assign bus1.flush_i = flush;  assign bus3.flush_i = flush;

  always #5 clk = ~clk;

  obs_t obs [2];
  always_comb begin
    obs[0] = {bus1.stall_o, bus1.ex_alusrc_o, bus1.ex_aluop_o, bus1.ex_rd_o, bus1.mem_read_o,
              bus1.mem_write_o, bus1.mem_branch_o, bus1.wb_regwr_o, bus1.wb_memtoreg_o, bus1.illegal_o};
    obs[1] = {bus3.stall_o, bus3.ex_alusrc_o, bus3.ex_aluop_o, bus3.ex_rd_o, bus3.mem_read_o,
              bus3.mem_write_o, bus3.mem_branch_o, bus3.wb_regwr_o, bus3.wb_memtoreg_o, bus3.illegal_o};
  end

  // Reference model: one stage record per pipeline slot, plus remaining stall cycles.
  stage_t mEx [2], mMem [2], mWb [2];
  int     stallLeft [2];
  logic   mIll [2];

  function automatic int stallLen(int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic logic isLegal(logic [6:0] op);
    return (op == OPC_R) || (op == OPC_I) || (op == OPC_LD) || (op == OPC_ST) || (op == OPC_BR);
  endfunction

  function automatic stage_t decodeRef(logic v, logic [6:0] op, logic [4:0] dst);
    stage_t s;
    s = '0;
    if (!v || !isLegal(op)) return s;
    if (op == OPC_R)  begin s.aluop = 2'b10; s.regwr = 1'b1; end
    if (op == OPC_I)  begin s.aluop = 2'b11; s.alusrc = 1'b1; s.regwr = 1'b1; end
    if (op == OPC_LD) begin s.aluop = 2'b00; s.alusrc = 1'b1; s.mread = 1'b1; s.regwr = 1'b1; s.m2r = 1'b1; end
    if (op == OPC_ST) begin s.aluop = 2'b00; s.alusrc = 1'b1; s.mwrite = 1'b1; end
    if (op == OPC_BR) begin s.aluop = 2'b01; s.branch = 1'b1; end
    s.rd = dst;
    if (dst == 5'd0) s.regwr = 1'b0;
    return s;
  endfunction

  function automatic logic hazard(int d);
    return (stallLeft[d] == 0) && mEx[d].mread && (mEx[d].rd != 5'd0) && vld &&
           ((mEx[d].rd == rs1) || (mEx[d].rd == rs2));
  endfunction

  function automatic logic expStall(int d);
    return (stallLeft[d] > 0) || (hazard(d) && !flush);
  endfunction

  function automatic obs_t expObs(int d);
    obs_t e;
    e.stall   = expStall(d);
    e.alusrc  = mEx[d].alusrc;
    e.aluop   = mEx[d].aluop;
    e.rd      = mEx[d].rd;
    e.mread   = mMem[d].mread;
    e.mwrite  = mMem[d].mwrite;
    e.branch  = mMem[d].branch;
    e.regwr   = mWb[d].regwr;
    e.m2r     = mWb[d].m2r;
    e.illegal = mIll[d];
    return e;
  endfunction

  task automatic clearModel();
    for (int d = 0; d < 2; d++) begin
      mEx[d] = '0; mMem[d] = '0; mWb[d] = '0; stallLeft[d] = 0; mIll[d] = 1'b0;
    end
  endtask

  task automatic drive(input logic v, input logic [6:0] op, input logic [4:0] a, input logic [4:0] b,
                       input logic [4:0] dst, input logic f);
    vld = v; opc = op; rs1 = a; rs2 = b; rd = dst; flush = f;
    #1;
  endtask

  task automatic advance();
    for (int d = 0; d < 2; d++) begin
      logic st, hz;
      st = expStall(d);
      hz = hazard(d);
      if (rstN) begin
        mWb[d]  = mMem[d];
        mMem[d] = mEx[d];
        mEx[d]  = (flush || st) ? stage_t'('0) : decodeRef(vld, opc, rd);
        if (flush) stallLeft[d] = 0;
        else if (stallLeft[d] > 0) stallLeft[d] = stallLeft[d] - 1;
        else if (hz) stallLeft[d] = stallLen(d) - 1;
`ifdef CTRL_ILLEGAL_EN
        if (vld && !isLegal(opc)) mIll[d] = 1'b1;
`endif
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clearModel();
    drive(0, 7'd0, 5'd0, 5'd0, 5'd0, 0);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obs[d] !== obs_t'('0)) begin
        errors++; $display("[TB] FAIL reset_state pipe%0d got %h want 0", d, obs[d]);
      end
    end
    @(posedge clk); #1;
    rstN = 1'b1;
    drive(1, OPC_LD, 5'd1, 5'd0, 5'd5, 0); advance();
    drive(0, 7'd0, 5'd0, 5'd0, 5'd0, 0);   advance();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obs[d] !== expObs(d) || obs[d].mread !== 1'b1) begin
        errors++; $display("[TB] FAIL load_in_mem pipe%0d got %h want %h", d, obs[d], expObs(d));
      end
    end
    rstN = 1'b0;
    clearModel();
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obs[d] !== obs_t'('0)) begin
        errors++; $display("[TB] FAIL async_reset pipe%0d got %h want 0", d, obs[d]);
      end
    end
    advance();
    rstN = 1'b1;
    for (int k = 0; k < 2; k++) begin
      drive(0, 7'd0, 5'd0, 5'd0, 5'd0, 0);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs[d] !== expObs(d)) begin
          errors++; $display("[TB] FAIL after_reset pipe%0d got %h want %h", d, obs[d], expObs(d));
        end
      end
      advance();
    end
  endtask

  task automatic test_rtype();
    drive(1, OPC_R, 5'd1, 5'd2, 5'd5, 0);
    advance();
    for (int k = 1; k <= 3; k++) begin
      drive(0, 7'd0, 5'd0, 5'd0, 5'd0, 0);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs[d] !== expObs(d) || obs[d].stall !== 1'b0) begin
          errors++; $display("[TB] FAIL rtype_T+%0d pipe%0d got %h want %h", k, d, obs[d], expObs(d));
        end
      end
      if (k == 1) begin
        checks++;
        if (bus1.ex_aluop_o !== 2'b10 || bus1.ex_rd_o !== 5'd5) begin
          errors++; $display("[TB] FAIL rtype_ex got aluop %b rd %0d want 10 rd 5", bus1.ex_aluop_o, bus1.ex_rd_o);
        end
      end
      if (k == 3) begin
        checks++;
        if (bus3.wb_regwr_o !== 1'b1) begin
          errors++; $display("[TB] FAIL rtype_wb got %b want 1", bus3.wb_regwr_o);
        end
      end
      advance();
    end
  endtask

  task automatic test_load_use();
    int sc1, sc3, first1, first3;
    sc1 = 0; sc3 = 0; first1 = -1; first3 = -1;
    drive(1, OPC_LD, 5'd1, 5'd0, 5'd5, 0);
    advance();
    for (int k = 0; k < 6; k++) begin
      if (k < 4) drive(1, OPC_R, 5'd5, 5'd1, 5'd6, 0);
      else       drive(0, 7'd0, 5'd0, 5'd0, 5'd0, 0);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs[d] !== expObs(d)) begin
          errors++; $display("[TB] FAIL load_use_k%0d pipe%0d got %h want %h", k, d, obs[d], expObs(d));
        end
      end
      sc1 += int'(bus1.stall_o);
      sc3 += int'(bus3.stall_o);
      if (first1 < 0 && bus1.ex_rd_o == 5'd6) first1 = k;
      if (first3 < 0 && bus3.ex_rd_o == 5'd6) first3 = k;
      advance();
    end
    checks++;
    if (sc1 != 1 || sc3 != 3) begin
      errors++; $display("[TB] FAIL stall_len got %0d/%0d want 1/3", sc1, sc3);
    end
    checks++;
    if (first1 != 2 || first3 != 4) begin
      errors++; $display("[TB] FAIL add_in_ex_cycle got %0d/%0d want 2/4", first1, first3);
    end
    drive(1, OPC_LD, 5'd1, 5'd0, 5'd0, 0);
    advance();
    drive(1, OPC_R, 5'd0, 5'd0, 5'd7, 0);
    checks++;
    if (bus1.stall_o !== 1'b0 || bus3.stall_o !== 1'b0) begin
      errors++; $display("[TB] FAIL x0_no_stall got %b/%b want 0/0", bus1.stall_o, bus3.stall_o);
    end
    advance();
    for (int k = 0; k < 3; k++) begin
      drive(0, 7'd0, 5'd0, 5'd0, 5'd0, 0);
      advance();
    end
  endtask

  task automatic test_flush();
    drive(1, OPC_LD, 5'd2, 5'd0, 5'd7, 0);
    advance();
    drive(1, OPC_R, 5'd7, 5'd3, 5'd8, 0);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obs[d] !== expObs(d) || obs[d].stall !== 1'b1) begin
        errors++; $display("[TB] FAIL flush_stall1 pipe%0d got %h want %h", d, obs[d], expObs(d));
      end
    end
    advance();
    drive(1, OPC_R, 5'd7, 5'd3, 5'd8, 1);
    checks++;
    if (bus3.stall_o !== 1'b1 || obs[0] !== expObs(0)) begin
      errors++; $display("[TB] FAIL flush_stall2 got %b want 1", bus3.stall_o);
    end
    advance();
    drive(0, 7'd0, 5'd0, 5'd0, 5'd0, 0);
    checks++;
    if (bus3.stall_o !== 1'b0 || {bus3.ex_alusrc_o, bus3.ex_aluop_o, bus3.ex_rd_o} !== 8'd0) begin
      errors++; $display("[TB] FAIL flush_abort got stall %b ex %h want 0 0", bus3.stall_o,
                         {bus3.ex_alusrc_o, bus3.ex_aluop_o, bus3.ex_rd_o});
    end
    for (int k = 0; k < 3; k++) begin
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs[d] !== expObs(d)) begin
          errors++; $display("[TB] FAIL flush_after pipe%0d got %h want %h", d, obs[d], expObs(d));
        end
      end
      advance();
      drive(0, 7'd0, 5'd0, 5'd0, 5'd0, 0);
    end
  endtask

  task automatic test_illegal();
    logic wantIll;
`ifdef CTRL_ILLEGAL_EN
    wantIll = 1'b1;
`else
    wantIll = 1'b0;
`endif
    drive(1, OPC_BAD, 5'd1, 5'd2, 5'd3, 0);
    checks++;
    if (bus1.illegal_o !== 1'b0) begin
      errors++; $display("[TB] FAIL illegal_early got %b want 0", bus1.illegal_o);
    end
    advance();
    for (int k = 0; k < 3; k++) begin
      drive(0, 7'd0, 5'd0, 5'd0, 5'd0, 0);
      checks++;
      if (bus1.illegal_o !== wantIll || bus3.illegal_o !== wantIll || (k == 0 && bus1.ex_rd_o !== 5'd0)) begin
        errors++; $display("[TB] FAIL illegal_flag_%0d got %b/%b want %b", k, bus1.illegal_o, bus3.illegal_o, wantIll);
      end
      advance();
    end
  endtask

  task automatic test_random();
    logic [6:0] opTable [6];
    opTable = '{OPC_R, OPC_I, OPC_LD, OPC_ST, OPC_BR, OPC_BAD};
    for (int n = 0; n < 400; n++) begin
      int pick;
      logic [6:0] op;
      pick = int'($urandom_range(0, 6));
      op = (pick == 6) ? 7'($urandom) : opTable[pick];
      drive(($urandom_range(0, 99) < 85), op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), ($urandom_range(0, 9) == 0));
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs[d] !== expObs(d)) begin
          errors++; $display("[TB] FAIL random_%0d pipe%0d got %h want %h", n, d, obs[d], expObs(d));
        end
      end
      advance();
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    vld = 1'b0; opc = '0; rs1 = '0; rs2 = '0; rd = '0; flush = 1'b0;
    test_reset();
    test_rtype();
    test_load_use();
    test_flush();
    test_illegal();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
